// File: rtl/deser_pkg.sv
// Shared types for the serial-to-parallel receive path.
// The mod field convention matches the serializer: zero stands for full width.
package deser_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Encoding of the valid-bit count for a completely filled word.
    localparam int MOD_FULL = 0;

endpackage

// File: rtl/deserializer.sv
// MSB-first serial stream to parallel word rebuilder with last-strobe support.
// Optional idle flush of partial words when DESER_TIMEOUT_EN is defined.
module deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MOD_W   = $clog2(WIDTH),
    parameter int TIMEOUT = 8
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             ser_data_i,
    input  logic             ser_data_val_i,
    input  logic             ser_last_i,
    output logic [WIDTH-1:0] deser_data_o,
    output logic [MOD_W-1:0] deser_data_mod_o,
    output logic             deser_data_val_o,
    output logic             busy_o
);

    generate
        if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
            $error("deserializer: WIDTH must be a power of two >= 4, TIMEOUT >= 1");
        end
    endgenerate

    state_t             state;
    logic [MOD_W:0]     count;
    logic [WIDTH-1:0]   shreg;

    logic [MOD_W-1:0]   pos;
    logic [MOD_W:0]     count_nxt;
    logic [WIDTH-1:0]   shreg_nxt;
    logic               full;
    logic               done;
    logic [MOD_W-1:0]   mod_enc;

    // For a power-of-two WIDTH, WIDTH-1-count is the bitwise inverse of count.
    always_comb begin
        pos            = ~count[MOD_W-1:0];
        shreg_nxt      = shreg;
        shreg_nxt[pos] = ser_data_i;
        count_nxt      = count + 1'b1;
        full           = count_nxt[MOD_W];
        done           = full || ser_last_i;
        mod_enc        = full ? MOD_W'(MOD_FULL) : count_nxt[MOD_W-1:0];
    end

`ifdef DESER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_cnt;
`endif

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state            <= IDLE;
            count            <= '0;
            shreg            <= '0;
            deser_data_o     <= '0;
            deser_data_mod_o <= '0;
            deser_data_val_o <= 1'b0;
`ifdef DESER_TIMEOUT_EN
            idle_cnt         <= '0;
`endif
        end else begin
            deser_data_val_o <= 1'b0;
            if (ser_data_val_i) begin
`ifdef DESER_TIMEOUT_EN
                idle_cnt <= '0;
`endif
                if (done) begin
                    deser_data_o     <= shreg_nxt;
                    deser_data_mod_o <= mod_enc;
                    deser_data_val_o <= 1'b1;
                    state            <= IDLE;
                    count            <= '0;
                    shreg            <= '0;
                end else begin
                    state <= COLLECT;
                    count <= count_nxt;
                    shreg <= shreg_nxt;
                end
            end
`ifdef DESER_TIMEOUT_EN
            else if (state == COLLECT) begin
                if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                    // Partial word: count is below WIDTH, so it is the mod as-is.
                    deser_data_o     <= shreg;
                    deser_data_mod_o <= count[MOD_W-1:0];
                    deser_data_val_o <= 1'b1;
                    state            <= IDLE;
                    count            <= '0;
                    shreg            <= '0;
                    idle_cnt         <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
`endif
        end
    end

    assign busy_o = (state == COLLECT);

endmodule

// File: tb/tb_deserializer.sv
// Randomized and directed bench for deserializer against a bit-queue model.
// Honors DESER_TIMEOUT_EN in the model and the directed timeout case.
module tb_deserializer;

    localparam int W    = 16;
    localparam int MW   = 4;
    localparam int TOUT = 8;

    logic          clk    = 1'b0;
    logic          arst_n = 1'b0;
    logic          sd     = 1'b0;
    logic          sv     = 1'b0;
    logic          sl     = 1'b0;
    logic [W-1:0]  dd;
    logic [MW-1:0] dm;
    logic          dv;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    deserializer #(
        .WIDTH   (W),
        .MOD_W   (MW),
        .TIMEOUT (TOUT)
    ) dut (
        .clk_i            (clk),
        .arst_n_i         (arst_n),
        .ser_data_i       (sd),
        .ser_data_val_i   (sv),
        .ser_last_i       (sl),
        .deser_data_o     (dd),
        .deser_data_mod_o (dm),
        .deser_data_val_o (dv),
        .busy_o           (busy)
    );

    // Model: the bits of the word in progress, in arrival order.
    bit               bits[$];
    int               idle_n = 0;
    logic [W-1:0]     m_data = '0;
    logic [MW-1:0]    m_mod  = '0;
    logic             m_val  = 1'b0;
    logic             m_busy = 1'b0;
    logic [W+MW-1:0]  mq[$];
    logic [W+MW-1:0]  dq[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic emit();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < bits.size(); i++) w[W-1-i] = bits[i];
        m_data = w;
        m_mod  = MW'(bits.size() % W);
        m_val  = 1'b1;
        mq.push_back({w, m_mod});
        bits.delete();
        idle_n = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge arst_n);
            if (!arst_n) begin
                bits.delete();
                idle_n = 0;
                m_data = '0;
                m_mod  = '0;
                m_val  = 1'b0;
                m_busy = 1'b0;
            end else begin
                m_val = 1'b0;
                if (sv) begin
                    bits.push_back(sd);
                    idle_n = 0;
                    if (sl || bits.size() == W) emit();
                end else if (bits.size() > 0) begin
`ifdef DESER_TIMEOUT_EN
                    idle_n++;
                    if (idle_n == TOUT) emit();
`endif
                end
                m_busy = (bits.size() > 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (arst_n) begin
                chk("val", dv, m_val);
                chk("busy", busy, m_busy);
                chk("data", dd, m_data);
                chk("mod", dm, m_mod);
                if (dv) dq.push_back({dd, dm});
            end
        end
    end

    task automatic drive(input logic v, input logic b, input logic l);
        sv = v;
        sd = b;
        sl = l;
        @(posedge clk);
        #1;
        sv = 1'b0;
        sd = 1'b0;
        sl = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int n,
                             input logic last_end, input int gap);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, w[W-1-i], last_end && (i == n - 1));
            if (i < n - 1) repeat (gap) drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic settle();
        repeat (3) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_word(input string nm, input logic [W-1:0] d,
                               input logic [MW-1:0] m);
        logic [W+MW-1:0] x;
        chk({nm, "_dut_cnt"}, (dq.size() > 0), 1);
        if (dq.size() > 0) begin
            x = dq.pop_front();
            chk({nm, "_dut_data"}, x[W+MW-1:MW], d);
            chk({nm, "_dut_mod"}, x[MW-1:0], m);
        end
        chk({nm, "_mdl_cnt"}, (mq.size() > 0), 1);
        if (mq.size() > 0) begin
            x = mq.pop_front();
            chk({nm, "_mdl_data"}, x[W+MW-1:MW], d);
            chk({nm, "_mdl_mod"}, x[MW-1:0], m);
        end
    endtask

    task automatic expect_none(input string nm);
        chk({nm, "_dut_extra"}, dq.size(), 0);
        chk({nm, "_mdl_extra"}, mq.size(), 0);
    endtask

    initial begin
        logic [W+MW-1:0] a;
        logic [W+MW-1:0] b;
        int r;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", dd, 0);
        chk("rst_mod", dm, 0);
        chk("rst_val", dv, 0);
        chk("rst_busy", busy, 0);
        arst_n = 1'b1;

        send_word(16'hF0F0, 16, 1'b0, 0);
        chk("full_pulse_now", dv, 1);
        chk("full_busy_after", busy, 0);
        settle();
        expect_word("full", 16'hF0F0, 4'd0);
        expect_none("full_once");

        send_word(16'hA000, 3, 1'b1, 0);
        settle();
        expect_word("short", 16'hA000, 4'd3);
        expect_none("short_once");

        send_word(16'h1234, 16, 1'b0, 2);
        send_word(16'hABCD, 16, 1'b0, 0);
        settle();
        expect_word("gap_1234", 16'h1234, 4'd0);
        expect_word("b2b_abcd", 16'hABCD, 4'd0);
        expect_none("b2b_once");

        send_word(16'h5A5A, 16, 1'b1, 0);
        settle();
        expect_word("last16", 16'h5A5A, 4'd0);
        expect_none("last16_once");

        drive(1'b0, 1'b1, 1'b1);
        settle();
        expect_none("last_noval_idle");
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        settle();
        expect_word("last_noval_mid", 16'hC000, 4'd3);
        expect_none("last_noval_once");

        send_word(16'h8000, 1, 1'b1, 0);
        settle();
        expect_word("single", 16'h8000, 4'd1);

        send_word(16'hFFFF, 5, 1'b0, 0);
        #2;
        arst_n = 1'b0;
        #1;
        chk("rstmid_data", dd, 0);
        chk("rstmid_mod", dm, 0);
        chk("rstmid_val", dv, 0);
        chk("rstmid_busy", busy, 0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        expect_none("rstmid_nopulse");
        send_word(16'hC3C3, 16, 1'b0, 0);
        settle();
        expect_word("after_rst", 16'hC3C3, 4'd0);

        send_word(16'hD000, 4, 1'b0, 0);
        repeat (12) drive(1'b0, 1'b0, 1'b0);
`ifdef DESER_TIMEOUT_EN
        expect_word("timeout", 16'hD000, 4'd4);
        chk("timeout_busy", busy, 0);
`else
        expect_none("no_timeout");
        chk("no_timeout_busy", busy, 1);
        drive(1'b1, 1'b0, 1'b1);
        settle();
        expect_word("close", 16'hD000, 4'd5);
`endif

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                repeat ($urandom_range(5, 12)) drive(1'b0, 1'b0, 1'b0);
            end else begin
                drive(r < 70, 1'($urandom), $urandom_range(0, 9) == 0);
            end
        end
        settle();
        chk("rand_word_count", dq.size(), mq.size());
        while (dq.size() > 0 && mq.size() > 0) begin
            a = dq.pop_front();
            b = mq.pop_front();
            chk("rand_word", a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart of the team's serializer: accepts a 1-bit MSB-first stream with a per-bit valid and rebuilds parallel words.
- Emits each word with its valid-bit count in the serializer's data_mod convention, where 0 means the full WIDTH.
- Sits downstream of a serializer or serial link and feeds parallel consumers.
- Supports full-width words and short words terminated by a last strobe.

Parameters:
- WIDTH, 16: parallel word width in bits; must be a power of two, at least 4.
- MOD_W, $clog2(WIDTH): width of the count/mod field.
- TIMEOUT, 8: idle cycles before a partial word is flushed; used only when DESER_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  single clock; all logic on its rising edge.
- arst_n_i  in  1  asynchronous, active-low reset.
- ser_data_i  in  1  serial data bit, MSB first.
- ser_data_val_i  in  1  ser_data_i is valid this cycle; no backpressure, so every valid bit is consumed.
- ser_last_i  in  1  qualified by ser_data_val_i; the current bit is the last bit of the word.
- deser_data_o  out  WIDTH  assembled word, left-justified; unused low bits are 0.
- deser_data_mod_o  out  MOD_W  number of valid bits; 0 means WIDTH.
- deser_data_val_o  out  1  one-cycle pulse; deser_data_o and deser_data_mod_o are valid.
- busy_o  out  1  high while a word is partially collected.

Behaviour:
- Reset (async assert, sync release): state IDLE, bit counter 0, shift register 0, all outputs 0.
- FSM states:
  - IDLE: no bits held. A valid bit loads it into bit WIDTH-1 of the shift register, sets count to 1 and moves to COLLECT. If ser_last_i is also high, the word is emitted with mod 1 and the FSM stays in IDLE.
  - COLLECT: each valid bit is written to position WIDTH-1-count and count increments.
  - Word completes when count reaches WIDTH, or when ser_last_i is high with a valid bit. The FSM then returns to IDLE, clears count and clears the shift register.
- Latency: deser_data_val_o pulses on the rising edge after the completing bit is sampled (1 clock).
- deser_data_o and deser_data_mod_o are registered. They hold their value until the next completed word and are not cleared after the pulse.
- Mod encoding: count == WIDTH gives mod 0; otherwise mod = count.
- The WIDTH-th bit with ser_last_i high produces exactly one word with mod 0, never a second empty word.
- Back-to-back words: a valid bit in the cycle after completion starts a new word; the output pulse and new collection overlap with no dead cycle.
- ser_last_i without ser_data_val_i is ignored.
- Gaps (ser_data_val_i low) in COLLECT hold state and count unchanged.
- busy_o = (state == COLLECT), registered.
- No zero-bit words are ever emitted.
- Reset mid-word discards the partial word with no output pulse.

Optional Feature:
- Macro: DESER_TIMEOUT_EN.
- When defined:
  - An idle counter in COLLECT increments on every cycle without ser_data_val_i and clears on any valid bit.
  - When it reaches TIMEOUT, the partial word is flushed: deser_data_val_o pulses next cycle with mod = count, and the FSM returns to IDLE.
  - A valid bit arriving in the same cycle the counter reaches TIMEOUT takes priority: the bit is accepted and the counter clears.
- When undefined: no counter is instantiated, and a partial word waits indefinitely for more bits or ser_last_i.

Decomposition:
- Package deser_pkg holds:
  - the state_t enum {IDLE, COLLECT};
  - the localparam rule that the MOD_W encoding of 0 means full width, shared with the serializer.
- No sub-module; the shift register, counter and timeout counter stay inline in one module.

Test Plan:
- Full word: 16 valid bits of 16'hF0F0 MSB-first, ser_last_i low -> one pulse 1 clk after the 16th bit; data 16'hF0F0, mod 0; busy_o high from bit 1 through bit 16, low after.
- Short word: bits 1,0,1 with ser_last_i on the 3rd -> data 16'hA000, mod 3, single pulse.
- Gaps plus back-to-back: 16'h1234 with 2-cycle gaps, then 16'hABCD starting the very next cycle -> two pulses, data 16'h1234 then 16'hABCD, both mod 0, no lost bit.
- Boundaries:
  - ser_last_i with the 16th bit -> exactly one pulse, mod 0.
  - ser_last_i with ser_data_val_i low -> no pulse.
  - A single bit 1 with ser_last_i from IDLE -> data 16'h8000, mod 1.
- Reset mid-word: 5 bits, assert arst_n_i low asynchronously -> outputs 0 immediately, no pulse; the next 16 bits form a clean word.
- With DESER_TIMEOUT_EN and TIMEOUT 8: 4 bits 1,1,0,1 then idle -> pulse after 8 idle cycles, data 16'hD000, mod 4.
- Without DESER_TIMEOUT_EN, the same stimulus -> no pulse and busy_o stays high.
